id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline, sitting between the IF/ID and ID/EX pipeline registers. It decodes the 32-bit instruction into execute, memory and write-back control signals and evaluates the condition field against the status flags. It reads two operands from an internal 15-entry register file and accepts the write-back port from the WB stage. All outputs are combinational; only the register file is clocked.

## Interface
Parameters: none.
- `clk`  in  1  system clock; register-file writes occur on the rising edge
- `rst`  in  1  reset, synchronous and active-high; one clock
- `flush`  in  1  branch-taken flush; forces control outputs to 0
- `freeze`  in  1  pipeline freeze; forces control outputs to 0
- `PCIn`  in  32  PC+4 from IF/ID
- `instructionReg`  in  32  instruction from IF/ID
- `writeBackEnIn`  in  1  register-file write enable from WB
- `destWB`  in  4  write-back destination register index
- `valueWB`  in  32  write-back data
- `hazard`  in  1  hazard-unit stall; forces control outputs to 0
- `statusReg`  in  4  flags {N,Z,C,V} in bits [3:0]
- `S_UpdateSig`  out  1  update status register in EX
- `branch`  out  1  branch instruction
- `memWriteEn`  out  1  STR
- `memReadEn`  out  1  LDR
- `writeBackEn`  out  1  result written to Rd
- `exeCMD`  out  4  ALU command
- `res1`  out  32  value of Rn (instr[19:16])
- `res2`  out  32  value of Rm (instr[3:0]); value of Rd (instr[15:12]) when memWriteEn would be set
- `PC`  out  32  equals PCIn
- `signedImm24`  out  24  instr[23:0]
- `R_d`  out  4  instr[15:12]
- `isImmidiate`  out  1  instr[25]
- `shiftOperand`  out  12  instr[11:0]

## Operation
- Field extraction: cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20].
- mode 00, data processing. exeCMD / writeBackEn per opcode:
  - MOV 1101→0001, WB
  - MVN 1111→1001, WB
  - ADD 0100→0010, WB
  - ADC 0101→0011, WB
  - SUB 0010→0100, WB
  - SBC 0110→0101, WB
  - AND 0000→0110, WB
  - ORR 1100→0111, WB
  - EOR 0001→1000, WB
  - CMP 1010→0100, no WB, S_UpdateSig = 1
  - TST 1000→0110, no WB, S_UpdateSig = 1
  - Other opcodes: all controls 0.
  - For non-compare instructions, S_UpdateSig = bit 20.
- mode 01, memory. bit 20 = 1 → LDR: memReadEn, writeBackEn, exeCMD 0010. bit 20 = 0 → STR: memWriteEn, exeCMD 0010. S_UpdateSig 0.
- mode 10: branch = 1; other controls 0.
- mode 11: all controls 0.
- Condition check, flags {N,Z,C,V}:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 never.
- Control gating: S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn and exeCMD are forced to 0 when the condition fails, or when hazard, flush or freeze is 1. Data outputs (res1, res2, PC, immediates, R_d) are never gated.
- Register file:
  - Holds R0–R14.
  - Reads of index 15 return 0; writes to index 15 are ignored.
  - Internal bypass: if writeBackEnIn && destWB == read index (≠15), the read returns valueWB in the same cycle.

## Timing
- Decode and reads are purely combinational, with zero-cycle latency.
- Register write happens at the rising clk edge when writeBackEnIn = 1. The value is visible via bypass in the same cycle and from the array after the edge.
- rst = 1 at a rising edge clears R0–R14 to 0. rst has priority over a simultaneous write.
- Control outputs have no reset state; they follow the inputs combinationally. During reset, reads return 0 after the first edge.

## Structure
- Shared package `arm_pkg`: opcode constants, exeCMD encodings, mode encodings, condition-code constants, flag bit positions.
- Sub-module `register_file`: 15×32 storage, two read ports, one write port, bypass, synchronous reset.
- Condition check and control decode are in-line combinational logic in id_stage.

## Test plan
- Reset then MOV R0,#20 (0xE3A00014), statusReg 0 → exeCMD 0001, writeBackEn 1, isImmidiate 1, shiftOperand 0x014, R_d 0, S 0.
- Write R0 = 0x14 via WB port, then ADC R4,R0,R0 (0xE0A04000) → exeCMD 0011, res1 = res2 = 0x14, R_d 4. With the write in the same cycle, the bypass gives the same result.
- CMP R1,R2 (0xE1510002) → S_UpdateSig 1, writeBackEn 0, exeCMD 0100. The same instruction with cond EQ and Z = 0 → all controls 0.
- LDR (0xE5910000) → memReadEn 1, writeBackEn 1, exeCMD 0010. STR (0xE5810004) → memWriteEn 1, res2 = R[Rd].
- B (0xEA000005) → branch 1, signedImm24 0x000005. The same with hazard = 1, flush = 1 or freeze = 1 → branch 0.
- Condition matrix: GT with Z = 0, N = V → pass. LE with N ≠ V → pass. cond 1111 → controls 0.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared encodings for the ARM-subset pipeline
package arm_pkg;

  localparam int NUM_REGS = 15;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    MODE_DP   = 2'b00,
    MODE_MEM  = 2'b01,
    MODE_BR   = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, pass;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - R0-R14 storage with two bypassed read ports and one write port
module register_file
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr1,
  input  logic [3:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [0:NUM_REGS-1];
  logic [31:0] regs_d [0:NUM_REGS-1];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != REG_PC) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index 15 is the PC slot: it has no storage and always reads as zero.
  assign rdata1 = (raddr1 == REG_PC)              ? '0    :
                  (we && waddr == raddr1)         ? wdata : regs_q[raddr1];
  assign rdata2 = (raddr2 == REG_PC)              ? '0    :
                  (we && waddr == raddr2)         ? wdata : regs_q[raddr2];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode: control decode, condition check, operand read
module id_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic [31:0] PCIn,
  input  logic [31:0] instructionReg,
  input  logic        writeBackEnIn,
  input  logic [3:0]  destWB,
  input  logic [31:0] valueWB,
  input  logic        hazard,
  input  logic [3:0]  statusReg,
  output logic        S_UpdateSig,
  output logic        branch,
  output logic        memWriteEn,
  output logic        memReadEn,
  output logic        writeBackEn,
  output logic [3:0]  exeCMD,
  output logic [31:0] res1,
  output logic [31:0] res2,
  output logic [31:0] PC,
  output logic [23:0] signedImm24,
  output logic [3:0]  R_d,
  output logic        isImmidiate,
  output logic [11:0] shiftOperand
);

  logic [3:0] cond;
  logic [3:0] opcode;
  mode_e      mode;
  logic       s_bit;
  logic       is_str;
  logic [3:0] src2_idx;
  logic       ctrl_en;

  logic       s_upd_raw, branch_raw, mem_w_raw, mem_r_raw, wb_raw;
  logic [3:0] cmd_raw;

  assign cond   = instructionReg[31:28];
  assign mode   = mode_e'(instructionReg[27:26]);
  assign opcode = instructionReg[24:21];
  assign s_bit  = instructionReg[20];

  // A store needs the data register (Rd) on the second port instead of Rm.
  assign is_str   = (mode == MODE_MEM) && !s_bit;
  assign src2_idx = is_str ? instructionReg[15:12] : instructionReg[3:0];

  register_file u_register_file (
    .clk    (clk),
    .rst    (rst),
    .we     (writeBackEnIn),
    .waddr  (destWB),
    .wdata  (valueWB),
    .raddr1 (instructionReg[19:16]),
    .raddr2 (src2_idx),
    .rdata1 (res1),
    .rdata2 (res2)
  );

  always_comb begin
    s_upd_raw  = 1'b0;
    branch_raw = 1'b0;
    mem_w_raw  = 1'b0;
    mem_r_raw  = 1'b0;
    wb_raw     = 1'b0;
    cmd_raw    = CMD_NOP;
    case (mode)
      MODE_DP: begin
        wb_raw    = 1'b1;
        s_upd_raw = s_bit;
        case (opcode)
          OP_MOV: cmd_raw = CMD_MOV;
          OP_MVN: cmd_raw = CMD_MVN;
          OP_ADD: cmd_raw = CMD_ADD;
          OP_ADC: cmd_raw = CMD_ADC;
          OP_SUB: cmd_raw = CMD_SUB;
          OP_SBC: cmd_raw = CMD_SBC;
          OP_AND: cmd_raw = CMD_AND;
          OP_ORR: cmd_raw = CMD_ORR;
          OP_EOR: cmd_raw = CMD_EOR;
          OP_CMP: begin
            cmd_raw   = CMD_SUB;
            wb_raw    = 1'b0;
            s_upd_raw = 1'b1;
          end
          OP_TST: begin
            cmd_raw   = CMD_AND;
            wb_raw    = 1'b0;
            s_upd_raw = 1'b1;
          end
          default: begin
            wb_raw    = 1'b0;
            s_upd_raw = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        cmd_raw   = CMD_ADD;
        mem_r_raw = s_bit;
        wb_raw    = s_bit;
        mem_w_raw = !s_bit;
      end
      MODE_BR: branch_raw = 1'b1;
      default: ;
    endcase
  end

  assign ctrl_en = cond_passed(cond, statusReg) && !(hazard || flush || freeze);

  assign S_UpdateSig = s_upd_raw  & ctrl_en;
  assign branch      = branch_raw & ctrl_en;
  assign memWriteEn  = mem_w_raw  & ctrl_en;
  assign memReadEn   = mem_r_raw  & ctrl_en;
  assign writeBackEn = wb_raw     & ctrl_en;
  assign exeCMD      = ctrl_en ? cmd_raw : CMD_NOP;

  assign PC           = PCIn;
  assign signedImm24  = instructionReg[23:0];
  assign R_d          = instructionReg[15:12];
  assign isImmidiate  = instructionReg[25];
  assign shiftOperand = instructionReg[11:0];

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, hazard, writeBackEnIn;
  logic [31:0] PCIn, instructionReg, valueWB;
  logic [3:0]  destWB, statusReg;
  logic        S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn, isImmidiate;
  logic [3:0]  exeCMD, R_d;
  logic [31:0] res1, res2, PC;
  logic [23:0] signedImm24;
  logic [11:0] shiftOperand;

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .PCIn(PCIn),
    .instructionReg(instructionReg), .writeBackEnIn(writeBackEnIn), .destWB(destWB),
    .valueWB(valueWB), .hazard(hazard), .statusReg(statusReg),
    .S_UpdateSig(S_UpdateSig), .branch(branch), .memWriteEn(memWriteEn),
    .memReadEn(memReadEn), .writeBackEn(writeBackEn), .exeCMD(exeCMD),
    .res1(res1), .res2(res2), .PC(PC), .signedImm24(signedImm24), .R_d(R_d),
    .isImmidiate(isImmidiate), .shiftOperand(shiftOperand)
  );

  always #5 clk = ~clk;

  // {S, branch, memW, memR, wb, cmd[3:0]}
  wire [8:0] ctrl_act = {S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEn, exeCMD};

  int total = 0;
  int bad = 0;
  logic [31:0] mreg [15];

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    logic        hz, fl, fr;
    logic [8:0]  ctrl;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [8:0] model_ctrl(input logic [31:0] ins, input logic [3:0] f, input bit stall);
    int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    int op;
    bit is_cmp;
    logic [8:0] r;
    op = int'(ins[24:21]);
    is_cmp = (op == 8) || (op == 10);
    r = '0;
    if (stall || !model_cond(ins[31:28], f)) return '0;
    case (ins[27:26])
      2'b00: if (dp_cmd[op] >= 0) begin
        r[3:0] = 4'(dp_cmd[op]);
        r[4]   = !is_cmp;
        r[8]   = is_cmp ? 1'b1 : ins[20];
      end
      2'b01: begin
        r[3:0] = 4'd2;
        r[4]   = ins[20];
        r[5]   = ins[20];
        r[6]   = !ins[20];
      end
      2'b10: r[7] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] idx, input logic we,
                                             input logic [3:0] dst, input logic [31:0] val);
    if (idx == 4'd15) return '0;
    if (we && dst == idx) return val;
    return mreg[idx];
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; hazard = 1'b0;
    writeBackEnIn = 1'b0; destWB = '0; valueWB = '0;
    PCIn = 32'h0000_0004; instructionReg = 32'hE3A0_0014; statusReg = 4'h0;

    // reset, then check rst beats a same-edge write
    tick();
    rst = 1'b0;
    writeBackEnIn = 1'b1; destWB = 4'd3; valueWB = 32'hDEAD_BEEF;
    tick();
    rst = 1'b1; valueWB = 32'h0000_1234;
    tick();
    rst = 1'b0; writeBackEnIn = 1'b0;
    instructionReg = 32'hE083_0000;
    #1;
    check("rst_priority_r3", res1, 32'h0);
    check("reset_r0", res2, 32'h0);

    instructionReg = 32'hE3A0_0014; PCIn = 32'h0000_1008;
    #1;
    check("mov_ctrl", 32'(ctrl_act), 32'h011);
    check("mov_imm_flag", 32'(isImmidiate), 32'h1);
    check("mov_shift_operand", 32'(shiftOperand), 32'h014);
    check("mov_rd", 32'(R_d), 32'h0);
    check("mov_imm24", 32'(signedImm24), 32'hA0_0014);
    check("mov_pc", PC, 32'h0000_1008);

    // ADC R4,R0,R0 with R0 write in the same cycle (bypass), then from the array
    instructionReg = 32'hE0A0_4000;
    writeBackEnIn = 1'b1; destWB = 4'd0; valueWB = 32'h14;
    #1;
    check("adc_bypass_res1", res1, 32'h14);
    check("adc_bypass_res2", res2, 32'h14);
    tick();
    writeBackEnIn = 1'b0; valueWB = 32'h0;
    #1;
    check("adc_array_res1", res1, 32'h14);
    check("adc_array_res2", res2, 32'h14);
    check("adc_ctrl", 32'(ctrl_act), 32'h013);
    check("adc_rd", 32'(R_d), 32'h4);

    // R15 reads as zero even when written
    instructionReg = 32'h000F_000F;
    writeBackEnIn = 1'b1; destWB = 4'd15; valueWB = 32'h5555_AAAA;
    #1;
    check("r15_bypass_res1", res1, 32'h0);
    tick();
    writeBackEnIn = 1'b0;
    #1;
    check("r15_array_res2", res2, 32'h0);

    // STR reads Rd on port 2, LDR reads Rm
    writeBackEnIn = 1'b1; destWB = 4'd5; valueWB = 32'hCAFE_0005;
    tick();
    destWB = 4'd4; valueWB = 32'h0000_0044;
    tick();
    writeBackEnIn = 1'b0;
    instructionReg = 32'hE581_5004;
    #1;
    check("str_res2_rd", res2, 32'hCAFE_0005);
    instructionReg = 32'hE591_5004;
    #1;
    check("ldr_res2_rm", res2, 32'h0000_0044);

    // control decode table
    vt.push_back('{32'hE3A00014, 4'h0, 1'b0, 1'b0, 1'b0, 9'h011});
    vt.push_back('{32'hE0A04000, 4'h0, 1'b0, 1'b0, 1'b0, 9'h013});
    vt.push_back('{32'hE1510002, 4'h0, 1'b0, 1'b0, 1'b0, 9'h104});
    vt.push_back('{32'h01510002, 4'h0, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'h01510002, 4'h4, 1'b0, 1'b0, 1'b0, 9'h104});
    vt.push_back('{32'hE5910000, 4'h0, 1'b0, 1'b0, 1'b0, 9'h032});
    vt.push_back('{32'hE5810004, 4'h0, 1'b0, 1'b0, 1'b0, 9'h042});
    vt.push_back('{32'hEA000005, 4'h0, 1'b0, 1'b0, 1'b0, 9'h080});
    vt.push_back('{32'hEA000005, 4'h0, 1'b1, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'hEA000005, 4'h0, 1'b0, 1'b1, 1'b0, 9'h000});
    vt.push_back('{32'hEA000005, 4'h0, 1'b0, 1'b0, 1'b1, 9'h000});
    vt.push_back('{32'hCA000005, 4'h9, 1'b0, 1'b0, 1'b0, 9'h080});
    vt.push_back('{32'hCA000005, 4'h4, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'hDA000005, 4'h8, 1'b0, 1'b0, 1'b0, 9'h080});
    vt.push_back('{32'hF3A00014, 4'hF, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'hE0600000, 4'h0, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'hE3B00014, 4'h0, 1'b0, 1'b0, 1'b0, 9'h111});
    vt.push_back('{32'hEC000000, 4'h0, 1'b0, 1'b0, 1'b0, 9'h000});
    vt.push_back('{32'hE1100002, 4'h0, 1'b0, 1'b0, 1'b0, 9'h106});

    for (int i = 0; i < vt.size(); i++) begin
      instructionReg = vt[i].ins; statusReg = vt[i].st;
      hazard = vt[i].hz; flush = vt[i].fl; freeze = vt[i].fr;
      #1;
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_act), 32'(vt[i].ctrl));
    end

    // randomized run against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 15; r++) mreg[r] = '0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins;
      bit stall;
      ins = $urandom;
      if ($urandom_range(1, 0) == 0) ins[31:28] = 4'hE;
      instructionReg = ins;
      statusReg = 4'($urandom);
      hazard = ($urandom_range(7, 0) == 0);
      flush  = ($urandom_range(7, 0) == 0);
      freeze = ($urandom_range(7, 0) == 0);
      writeBackEnIn = 1'($urandom);
      destWB = 4'($urandom);
      valueWB = $urandom;
      PCIn = $urandom;
      rst = ($urandom_range(19, 0) == 0);
      stall = hazard || flush || freeze;
      #1;
      check($sformatf("rnd%0d_ctrl", k), 32'(ctrl_act), 32'(model_ctrl(ins, statusReg, stall)));
      check($sformatf("rnd%0d_res1", k), res1,
            model_read(ins[19:16], writeBackEnIn, destWB, valueWB));
      check($sformatf("rnd%0d_res2", k), res2,
            model_read((ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0],
                       writeBackEnIn, destWB, valueWB));
      check($sformatf("rnd%0d_fields", k),
            {PC[7:0], signedImm24[11:0], R_d, isImmidiate, shiftOperand[6:0]},
            {PCIn[7:0], ins[11:0], ins[15:12], ins[25], ins[6:0]});
      tick();
      if (rst) begin
        for (int r = 0; r < 15; r++) mreg[r] = '0;
      end else if (writeBackEnIn && destWB != 4'd15) begin
        mreg[destWB] = valueWB;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
